// File: rtl/ffmon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ffmon_pkg
// Purpose  : Shared definitions for the flip-flop bank checker: FSM state
//            encoding, lane index map, per-lane cell-attribute masks and the
//            single-lane golden next-state function.
// Revision : 1.0 - initial release
// ============================================================================
package ffmon_pkg;

  localparam int N_LANES = 27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ffmon_state_e;

  // Lane index map of the legalized bank's Q bus
  localparam int LANE_DFF_P        = 0;
  localparam int LANE_DFF_N        = 1;
  localparam int LANE_DFFE_PP      = 2;
  localparam int LANE_DFFE_PN      = 3;
  localparam int LANE_DFFE_NP      = 4;
  localparam int LANE_SDFF_PP0     = 5;
  localparam int LANE_SDFF_PN0     = 6;
  localparam int LANE_SDFF_NP0     = 7;
  localparam int LANE_SDFF_PP1     = 8;
  localparam int LANE_SDFF_PN1     = 9;
  localparam int LANE_SDFF_NP1     = 10;
  localparam int LANE_SDFFE_PP0P   = 11;
  localparam int LANE_SDFFE_PP0N   = 12;
  localparam int LANE_SDFFE_PN0P   = 13;
  localparam int LANE_SDFFE_NP0P   = 14;
  localparam int LANE_SDFFE_PP1P   = 15;
  localparam int LANE_SDFFE_PP1N   = 16;
  localparam int LANE_SDFFE_PN1P   = 17;
  localparam int LANE_SDFFE_NP1P   = 18;
  localparam int LANE_SDFFCE_PP0P  = 19;
  localparam int LANE_SDFFCE_PP0N  = 20;
  localparam int LANE_SDFFCE_PN0P  = 21;
  localparam int LANE_SDFFCE_NP0P  = 22;
  localparam int LANE_SDFFCE_PP1P  = 23;
  localparam int LANE_SDFFCE_PP1N  = 24;
  localparam int LANE_SDFFCE_PN1P  = 25;
  localparam int LANE_SDFFCE_NP1P  = 26;

  // Per-lane cell attributes, one bit per lane
  localparam logic [N_LANES-1:0] NEG_LANE_MASK = 27'h4444492; // clocked on falling edge
  localparam logic [N_LANES-1:0] RVAL_MASK     = 27'h7878700; // sync reset loads 1
  localparam logic [N_LANES-1:0] EN_MASK       = 27'h7FFF81C; // has an enable pin
  localparam logic [N_LANES-1:0] EN_NEG_MASK   = 27'h1111008; // enable active low
  localparam logic [N_LANES-1:0] RST_MASK      = 27'h7FFFFE0; // has a sync reset pin
  localparam logic [N_LANES-1:0] RST_NEG_MASK  = 27'h2222240; // sync reset active low
  localparam logic [N_LANES-1:0] CE_MASK       = 27'h7F80000; // reset gated by enable

  // Next state of one lane given the shared stimulus and its cell attributes.
  // Non-CE cells: reset dominates enable. CE cells: nothing happens unless
  // the enable is active, then reset dominates data.
  function automatic logic lane_next(
    input logic q,
    input logic e,
    input logic r,
    input logic d,
    input logic has_en,
    input logic en_neg,
    input logic has_rst,
    input logic rst_neg,
    input logic rval,
    input logic ce
  );
    logic en_act;
    logic rst_act;
    logic n;
    en_act  = has_en  ? (e ^ en_neg)  : 1'b1;
    rst_act = has_rst ? (r ^ rst_neg) : 1'b0;
    if (ce) n = en_act ? (rst_act ? rval : d) : q;
    else    n = rst_act ? rval : (en_act ? d : q);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ffmon_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : ffmon_lfsr
// Purpose  : Seedable 16-bit Fibonacci LFSR, taps 16,14,13,11 (shift left,
//            feedback into bit 0).
// Ports    : clk      - clock
//            rst      - asynchronous active-high reset (state <= SEED)
//            i_load   - reload SEED (has priority over i_step)
//            i_step   - advance one step
//            o_state  - current LFSR state
// Revision : 1.0 - initial release
// ============================================================================
module ffmon_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  output logic [15:0] o_state
);

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb = r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_state <= SEED;
    else if (i_load) r_state <= SEED;
    else if (i_step) r_state <= {r_state[14:0], w_fb};
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/ffmon_bank_checker.sv
`default_nettype none
// ============================================================================
// Module   : ffmon_bank_checker
// Purpose  : Drives the 27-lane legalized flop bank with LFSR stimulus,
//            compares its Q against a per-lane golden model and reports
//            pass/fail with a saturating error counter and sticky lane mask.
// Ports    : C, R              - clock (shared with bank), async reset
//            start             - one-cycle run request (IDLE or DONE only)
//            q_obs[26:0]       - bank outputs
//            stim_e/r/d        - registered bank enable / sync reset / data
//            busy, done, pass  - run status
//            err_cnt[ERR_W-1:0]- mismatching cycles, saturating
//            fail_mask[26:0]   - sticky per-lane mismatch
//            first_fail_idx/first_fail_lanes - only with FFMON_FIRST_FAIL_EN
// Config   : `define FFMON_FIRST_FAIL_EN to add first-failure capture.
// Revision : 1.0 - initial release
// ============================================================================
module ffmon_bank_checker
  import ffmon_pkg::*;
#(
  parameter int          N_VECTORS = 1024,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          ERR_W     = 16
) (
  input  logic              C,
  input  logic              R,
  input  logic              start,
  input  logic [26:0]       q_obs,
  output logic              stim_e,
  output logic              stim_r,
  output logic              stim_d,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [26:0]       fail_mask
`ifdef FFMON_FIRST_FAIL_EN
  ,
  output logic [15:0]       first_fail_idx,
  output logic [26:0]       first_fail_lanes
`endif
);

  localparam logic [31:0] c_LAST = 32'(N_VECTORS - 1);

  ffmon_state_e      r_state;
  ffmon_state_e      w_state_next;
  logic [15:0]       w_lfsr;
  logic              r_stim_e;
  logic              r_stim_r;
  logic              r_stim_d;
  logic [26:0]       r_gold;
  logic [26:0]       w_gold_next;
  logic [26:0]       w_expect;
  logic [26:0]       w_mismatch;
  logic              w_any_mis;
  logic [31:0]       r_vec_cnt;
  logic              w_last;
  logic [ERR_W-1:0]  r_err;
  logic [26:0]       r_mask;

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge C or posedge R) begin
    if (R) r_state <= ST_IDLE;
    else   r_state <= w_state_next;
  end

  assign w_last = (r_vec_cnt == c_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_SEED;
      ST_SEED: w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: if (start) w_state_next = ST_SEED;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_SEED) || (r_state == ST_RUN);
    done = (r_state == ST_DONE);
    pass = (r_state == ST_DONE) && (r_err == '0);
  end

  // --------------------------------------------------------------------------
  // Stimulus source
  // --------------------------------------------------------------------------
  ffmon_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (C),
    .rst     (R),
    .i_load  (r_state == ST_SEED),
    .i_step  (r_state == ST_RUN),
    .o_state (w_lfsr)
  );

  // --------------------------------------------------------------------------
  // Golden model. Posedge lanes are compared against the stored state (the
  // bank updates at the same edge the checker samples). Negedge lanes already
  // captured the current stimulus mid-cycle, so they are compared against the
  // next state computed from it.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    assign w_gold_next[gi] = lane_next(r_gold[gi], r_stim_e, r_stim_r, r_stim_d,
                                       EN_MASK[gi], EN_NEG_MASK[gi],
                                       RST_MASK[gi], RST_NEG_MASK[gi],
                                       RVAL_MASK[gi], CE_MASK[gi]);
    assign w_expect[gi]    = NEG_LANE_MASK[gi] ? w_gold_next[gi] : r_gold[gi];
  end

  assign w_mismatch = q_obs ^ w_expect;
  assign w_any_mis  = |w_mismatch;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_stim_e  <= 1'b0;
      r_stim_r  <= 1'b0;
      r_stim_d  <= 1'b0;
      r_gold    <= '0;
      r_vec_cnt <= '0;
      r_err     <= '0;
      r_mask    <= '0;
    end else begin
      case (r_state)
        ST_SEED: begin
          r_gold    <= q_obs;
          r_vec_cnt <= '0;
          r_err     <= '0;
          r_mask    <= '0;
        end
        ST_RUN: begin
          r_stim_d  <= w_lfsr[0];
          r_stim_e  <= w_lfsr[1];
          r_stim_r  <= w_lfsr[2];
          r_gold    <= w_gold_next;
          r_vec_cnt <= r_vec_cnt + 32'd1;
          if (w_any_mis) begin
            if (r_err != {ERR_W{1'b1}}) r_err <= r_err + ERR_W'(1);
            r_mask <= r_mask | w_mismatch;
          end
        end
        default: ;
      endcase
    end
  end

  assign stim_e    = r_stim_e;
  assign stim_r    = r_stim_r;
  assign stim_d    = r_stim_d;
  assign err_cnt   = r_err;
  assign fail_mask = r_mask;

`ifdef FFMON_FIRST_FAIL_EN
  // Capture of the first failing compare of a run
  logic        r_ff_seen;
  logic [15:0] r_ff_idx;
  logic [26:0] r_ff_lanes;

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_ff_seen  <= 1'b0;
      r_ff_idx   <= '0;
      r_ff_lanes <= '0;
    end else if (r_state == ST_SEED) begin
      r_ff_seen  <= 1'b0;
      r_ff_idx   <= '0;
      r_ff_lanes <= '0;
    end else if ((r_state == ST_RUN) && w_any_mis && !r_ff_seen) begin
      r_ff_seen  <= 1'b1;
      r_ff_idx   <= r_vec_cnt[15:0];
      r_ff_lanes <= w_mismatch;
    end
  end

  assign first_fail_idx   = r_ff_idx;
  assign first_fail_lanes = r_ff_lanes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ffmon_bank_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ffmon_bank_checker
// Purpose  : Directed testbench for ffmon_bank_checker. Contains a
//            behavioural 27-lane flop bank (with selectable faults) driven by
//            the checker's stimulus outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ffmon_bank_checker;

  localparam logic [26:0] TB_NEG = 27'h4444492;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [26:0] bq_a = '0;
  logic [26:0] bq_b = '0;
  wire  [26:0] qobs_b = bq_b | 27'h0000020;   // lane 5 stuck at 1

  logic        e_a, r_a, d_a, busy_a, done_a, pass_a;
  logic [15:0] err_a;
  logic [26:0] mask_a;
  logic        e_b, r_b, d_b, busy_b, done_b, pass_b;
  logic [3:0]  err_b;
  logic [26:0] mask_b;
`ifdef FFMON_FIRST_FAIL_EN
  logic [15:0] ffi_a, ffi_b;
  logic [26:0] ffl_a, ffl_b;
`endif

  int fault  = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ffmon_bank_checker dut_a (
    .C(clk), .R(rst), .start(start_a), .q_obs(bq_a),
    .stim_e(e_a), .stim_r(r_a), .stim_d(d_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .fail_mask(mask_a)
`ifdef FFMON_FIRST_FAIL_EN
    , .first_fail_idx(ffi_a), .first_fail_lanes(ffl_a)
`endif
  );

  ffmon_bank_checker #(.N_VECTORS(64), .ERR_W(4)) dut_b (
    .C(clk), .R(rst), .start(start_b), .q_obs(qobs_b),
    .stim_e(e_b), .stim_r(r_b), .stim_d(d_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .fail_mask(mask_b)
`ifdef FFMON_FIRST_FAIL_EN
    , .first_fail_idx(ffi_b), .first_fail_lanes(ffl_b)
`endif
  );

  // Behavioural bank: next value of every lane, written cell by cell.
  // flt 1: lane 13 wired as PP0P; flt 2: lane 20 behaves as SDFFE.
  function automatic logic [26:0] bank_next(input logic [26:0] q, input logic e,
                                            input logic r, input logic d, input int flt);
    logic [26:0] n;
    n = q;
    n[0] = d;  n[1] = d;
    if (e)  n[2] = d;
    if (!e) n[3] = d;
    if (e)  n[4] = d;
    n[5] = r ? 1'b0 : d;  n[6] = r ? d : 1'b0;  n[7]  = r ? 1'b0 : d;
    n[8] = r ? 1'b1 : d;  n[9] = r ? d : 1'b1;  n[10] = r ? 1'b1 : d;
    if (r) n[11] = 1'b0; else if (e)  n[11] = d;
    if (r) n[12] = 1'b0; else if (!e) n[12] = d;
    if (flt == 1) begin
      if (r) n[13] = 1'b0; else if (e) n[13] = d;
    end else begin
      if (!r) n[13] = 1'b0; else if (e) n[13] = d;
    end
    if (r)  n[14] = 1'b0; else if (e)  n[14] = d;
    if (r)  n[15] = 1'b1; else if (e)  n[15] = d;
    if (r)  n[16] = 1'b1; else if (!e) n[16] = d;
    if (!r) n[17] = 1'b1; else if (e)  n[17] = d;
    if (r)  n[18] = 1'b1; else if (e)  n[18] = d;
    if (e) n[19] = r ? 1'b0 : d;
    if (flt == 2) begin
      if (r) n[20] = 1'b0; else if (!e) n[20] = d;
    end else begin
      if (!e) n[20] = r ? 1'b0 : d;
    end
    if (e)  n[21] = r ? d : 1'b0;
    if (e)  n[22] = r ? 1'b0 : d;
    if (e)  n[23] = r ? 1'b1 : d;
    if (!e) n[24] = r ? 1'b1 : d;
    if (e)  n[25] = r ? d : 1'b1;
    if (e)  n[26] = r ? 1'b1 : d;
    return n;
  endfunction

  always @(posedge clk) begin
    bq_a <= (bank_next(bq_a, e_a, r_a, d_a, fault) & ~TB_NEG) | (bq_a & TB_NEG);
    bq_b <= (bank_next(bq_b, e_b, r_b, d_b, 0)     & ~TB_NEG) | (bq_b & TB_NEG);
  end
  always @(negedge clk) begin
    bq_a <= (bank_next(bq_a, e_a, r_a, d_a, fault) & TB_NEG) | (bq_a & ~TB_NEG);
    bq_b <= (bank_next(bq_b, e_b, r_b, d_b, 0)     & TB_NEG) | (bq_b & ~TB_NEG);
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Pulse start_a for one edge; returns #1 after that edge.
  task automatic pulse_start_a;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
  endtask

  // Start a run and return the number of edges until done (-1 on timeout).
  task automatic run_a(output int lat);
    pulse_start_a();
    lat = -1;
    for (int i = 1; i <= 1200; i++) begin
      @(posedge clk); #1;
      if (done_a) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({e_a, r_a, d_a} !== 3'b000) begin errors++; $display("FAIL reset_stim got %b want 000", {e_a, r_a, d_a}); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass_a); end
    checks++; if (err_a !== 16'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_a); end
    checks++; if (mask_a !== 27'd0) begin errors++; $display("FAIL reset_mask got %h want 0", mask_a); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_clean_run;
    logic [15:0] lf;
    int lat;
    fault = 0;
    lf = 16'hACE1;
    lat = -1;
    pulse_start_a();
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL seed_busy got %b want 1", busy_a); end
    for (int i = 1; i <= 1200; i++) begin
      @(posedge clk); #1;
      if (i >= 2 && i <= 9) begin
        checks++;
        if ({r_a, e_a, d_a} !== lf[2:0]) begin
          errors++; $display("FAIL stim_vec%0d got %b want %b", i - 2, {r_a, e_a, d_a}, lf[2:0]);
        end
        lf = lfsr_step(lf);
      end
      if (done_a) begin lat = i; break; end
    end
    checks++; if (lat !== 1025) begin errors++; $display("FAIL clean_latency got %0d want 1025", lat); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL clean_pass got %b want 1", pass_a); end
    checks++; if (err_a !== 16'd0) begin errors++; $display("FAIL clean_err got %0d want 0", err_a); end
    checks++; if (mask_a !== 27'd0) begin errors++; $display("FAIL clean_mask got %h want 0", mask_a); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({done_a, pass_a, busy_a} !== 3'b110) begin errors++; $display("FAIL clean_hold got %b want 110", {done_a, pass_a, busy_a}); end
  endtask

  task automatic test_lane13_polarity;
    int lat;
    fault = 1;
    repeat (3) @(posedge clk);
    run_a(lat);
    checks++; if (lat !== 1025) begin errors++; $display("FAIL l13_latency got %0d want 1025", lat); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL l13_pass got %b want 0", pass_a); end
    checks++; if (mask_a !== 27'h0002000) begin errors++; $display("FAIL l13_mask got %h want 0002000", mask_a); end
    checks++; if (err_a == 16'd0) begin errors++; $display("FAIL l13_err got %0d want >0", err_a); end
  endtask

  task automatic test_lane20_ce;
    int lat;
    fault = 2;
    repeat (3) @(posedge clk);
    run_a(lat);
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL l20_pass got %b want 0", pass_a); end
    checks++; if (mask_a !== 27'h0100000) begin errors++; $display("FAIL l20_mask got %h want 0100000", mask_a); end
`ifdef FFMON_FIRST_FAIL_EN
    checks++; if (ffl_a !== 27'h0100000) begin errors++; $display("FAIL l20_first_lanes got %h want 0100000", ffl_a); end
`endif
  endtask

  task automatic test_reset_midrun;
    int  lat;
    logic saw_done;
    fault = 0;
    repeat (3) @(posedge clk);
    pulse_start_a();
    repeat (501) @(posedge clk);
    #1; rst = 1'b1; #1;
    checks++; if ({busy_a, done_a, pass_a} !== 3'b000) begin errors++; $display("FAIL rstmid_status got %b want 000", {busy_a, done_a, pass_a}); end
    checks++; if ({e_a, r_a, d_a} !== 3'b000) begin errors++; $display("FAIL rstmid_stim got %b want 000", {e_a, r_a, d_a}); end
    checks++; if ((err_a !== 16'd0) || (mask_a !== 27'd0)) begin errors++; $display("FAIL rstmid_counters got %0d/%h want 0/0", err_a, mask_a); end
    @(posedge clk); #1; rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      if (done_a) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got %b want 0", saw_done); end
    run_a(lat);
    checks++; if (lat !== 1025) begin errors++; $display("FAIL rstmid_rerun_latency got %0d want 1025", lat); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL rstmid_rerun_pass got %b want 1", pass_a); end
  endtask

  task automatic test_saturate;
    int lat;
    lat = -1;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done_b) begin lat = i; break; end
    end
    checks++; if (lat !== 65) begin errors++; $display("FAIL sat_latency got %0d want 65", lat); end
    checks++; if (err_b !== 4'd15) begin errors++; $display("FAIL sat_err got %0d want 15", err_b); end
    checks++; if (pass_b !== 1'b0) begin errors++; $display("FAIL sat_pass got %b want 0", pass_b); end
    checks++; if (mask_b !== 27'h0000020) begin errors++; $display("FAIL sat_mask got %h want 0000020", mask_b); end
  endtask

  task automatic test_start_during_run;
    int   rises;
    logic prev;
    fault = 0;
    repeat (3) @(posedge clk);
    pulse_start_a();
    rises = 0;
    prev  = done_a;
    for (int i = 1; i <= 1030; i++) begin
      if (i == 300 || i == 1025) start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      if (done_a && !prev) rises++;
      prev = done_a;
      if (i == 1024) begin
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL sdr_early_done got %b want 0", done_a); end
      end
      if (i == 1025) begin
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL sdr_nominal_done got %b want 1", done_a); end
      end
    end
    checks++; if ({busy_a, done_a} !== 2'b01) begin errors++; $display("FAIL sdr_no_restart got %b want 01", {busy_a, done_a}); end
    checks++; if (rises !== 1) begin errors++; $display("FAIL sdr_done_count got %0d want 1", rises); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL sdr_pass got %b want 1", pass_a); end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_lane13_polarity();
    test_lane20_ce();
    test_reset_midrun();
    test_saturate();
    test_start_during_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
